// File: rtl/merge_stage_kway_combine.sv
// NUM_ATOMS independent 2-to-1 merge atoms. Each atom merges two key-sorted
// {last, key, val} streams from its two input FIFOs into one registered sorted stream.
module merge_stage_kway_combine #(
    parameter int NUM_ATOMS  = 4,
    parameter int KEY_WIDTH  = 32,
    parameter int VAL_WIDTH  = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int COMBINE_EQ = 1,
    localparam int DW        = 1 + KEY_WIDTH + VAL_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            global_en,
    input  logic [2*NUM_ATOMS-1:0]          fifo_wr_en,
    input  logic [2*NUM_ATOMS-1:0][DW-1:0]  data_in,
    input  logic [NUM_ATOMS-1:0]            next_fifo_full,
    output logic [2*NUM_ATOMS-1:0]          fifo_full,
    output logic [NUM_ATOMS-1:0]            next_fifo_wr_en,
    output logic [NUM_ATOMS-1:0][DW-1:0]    data_out,
    output logic [NUM_ATOMS-1:0]            overflow_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] ALMOST_C = (AW+1)'(FIFO_DEPTH - 1);

    // DRAIN1: side 0 has finished its stream (done0), side 1 still draining.
    typedef enum logic [1:0] {
        ST_MERGE  = 2'd0,
        ST_DRAIN1 = 2'd1,
        ST_DRAIN0 = 2'd2
    } state_t;

    for (genvar a = 0; a < NUM_ATOMS; a++) begin : g_atom
        logic [DW-1:0]        mem_r [2][FIFO_DEPTH];
        logic [AW-1:0]        rd_ptr_r [2];
        logic [AW-1:0]        wr_ptr_r [2];
        logic [AW:0]          count_r [2];
        logic [AW:0]          count_nxt_s [2];
        logic [1:0][DW-1:0]   din_s;
        logic [1:0]           wr_en_s;
        logic [1:0]           full_r;
        logic [1:0]           empty_s;
        logic [1:0]           push_s;
        logic [1:0]           pop_s;
        logic                 overflow_r;
        logic                 out_valid_r;
        logic                 emit_s;
        logic [DW-1:0]        dout_r;
        logic [DW-1:0]        emit_data_s;
        logic [DW-1:0]        h0_s;
        logic [DW-1:0]        h1_s;
        logic [KEY_WIDTH-1:0] k0_s;
        logic [KEY_WIDTH-1:0] k1_s;
        logic [VAL_WIDTH-1:0] v0_s;
        logic [VAL_WIDTH-1:0] v1_s;
        logic                 l0_s;
        logic                 l1_s;
        state_t               state_r;
        state_t               state_nxt_s;

        assign din_s      = data_in[2*a +: 2];
        assign wr_en_s    = fifo_wr_en[2*a +: 2];
        assign empty_s[0] = (count_r[0] == '0);
        assign empty_s[1] = (count_r[1] == '0);
        assign h0_s       = mem_r[0][rd_ptr_r[0]];
        assign h1_s       = mem_r[1][rd_ptr_r[1]];
        assign l0_s       = h0_s[DW-1];
        assign l1_s       = h1_s[DW-1];
        assign k0_s       = h0_s[VAL_WIDTH +: KEY_WIDTH];
        assign k1_s       = h1_s[VAL_WIDTH +: KEY_WIDTH];
        assign v0_s       = h0_s[VAL_WIDTH-1:0];
        assign v1_s       = h1_s[VAL_WIDTH-1:0];

        // Merge decision: which heads to pop and what to emit this cycle.
        always_comb begin
            pop_s       = 2'b00;
            emit_s      = 1'b0;
            emit_data_s = '0;
            state_nxt_s = state_r;
            if (global_en && !next_fifo_full[a]) begin
                case (state_r)
                    ST_MERGE: begin
                        if (!empty_s[0] && !empty_s[1]) begin
                            if ((k0_s < k1_s) || ((k0_s == k1_s) && (COMBINE_EQ == 0))) begin
                                emit_s      = 1'b1;
                                emit_data_s = {1'b0, k0_s, v0_s};
                                pop_s       = 2'b01;
                                state_nxt_s = l0_s ? ST_DRAIN1 : ST_MERGE;
                            end else if (k1_s < k0_s) begin
                                emit_s      = 1'b1;
                                emit_data_s = {1'b0, k1_s, v1_s};
                                pop_s       = 2'b10;
                                state_nxt_s = l1_s ? ST_DRAIN0 : ST_MERGE;
                            end else begin
                                // Equal keys summed; the sum wraps at VAL_WIDTH.
                                emit_s      = 1'b1;
                                emit_data_s = {l0_s & l1_s, k0_s, v0_s + v1_s};
                                pop_s       = 2'b11;
                                if (l0_s && l1_s) begin
                                    state_nxt_s = ST_MERGE;
                                end else if (l0_s) begin
                                    state_nxt_s = ST_DRAIN1;
                                end else if (l1_s) begin
                                    state_nxt_s = ST_DRAIN0;
                                end else begin
                                    state_nxt_s = ST_MERGE;
                                end
                            end
                        end else begin
                            state_nxt_s = state_r;
                        end
                    end
                    ST_DRAIN1: begin
                        if (!empty_s[1]) begin
                            emit_s      = 1'b1;
                            emit_data_s = h1_s;
                            pop_s       = 2'b10;
                            state_nxt_s = l1_s ? ST_MERGE : ST_DRAIN1;
                        end else begin
                            state_nxt_s = state_r;
                        end
                    end
                    ST_DRAIN0: begin
                        if (!empty_s[0]) begin
                            emit_s      = 1'b1;
                            emit_data_s = h0_s;
                            pop_s       = 2'b01;
                            state_nxt_s = l0_s ? ST_MERGE : ST_DRAIN0;
                        end else begin
                            state_nxt_s = state_r;
                        end
                    end
                    default: state_nxt_s = ST_MERGE;
                endcase
            end else begin
                state_nxt_s = state_r;
            end
        end

        // Push acceptance: a full FIFO only takes a push when it is popped in the same cycle.
        always_comb begin
            for (int j = 0; j < 2; j++) begin
                push_s[j]      = wr_en_s[j] && ((count_r[j] != DEPTH_C) || pop_s[j]);
                count_nxt_s[j] = count_r[j] + (AW+1)'(push_s[j]) - (AW+1)'(pop_s[j]);
            end
        end

        // FIFO storage, no reset needed on the data array.
        always_ff @(posedge clk) begin
            for (int j = 0; j < 2; j++) begin
                if (push_s[j] && !rst) begin
                    mem_r[j][wr_ptr_r[j]] <= din_s[j];
                end
            end
        end

        // FIFO pointers, occupancy, almost-full and sticky overflow.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int j = 0; j < 2; j++) begin
                    rd_ptr_r[j] <= '0;
                    wr_ptr_r[j] <= '0;
                    count_r[j]  <= '0;
                end
                full_r     <= 2'b00;
                overflow_r <= 1'b0;
            end else begin
                for (int j = 0; j < 2; j++) begin
                    if (push_s[j]) begin
                        wr_ptr_r[j] <= wr_ptr_r[j] + AW'(1);
                    end
                    if (pop_s[j]) begin
                        rd_ptr_r[j] <= rd_ptr_r[j] + AW'(1);
                    end
                    count_r[j] <= count_nxt_s[j];
                    full_r[j]  <= (count_nxt_s[j] >= ALMOST_C);
                end
                if ((wr_en_s & ~push_s) != 2'b00) begin
                    overflow_r <= 1'b1;
                end
            end
        end

        // Stream state and registered output entry.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_r     <= ST_MERGE;
                out_valid_r <= 1'b0;
                dout_r      <= '0;
            end else begin
                state_r     <= state_nxt_s;
                out_valid_r <= emit_s;
                if (emit_s) begin
                    dout_r <= emit_data_s;
                end
            end
        end

        assign fifo_full[2*a +: 2] = full_r;
        assign next_fifo_wr_en[a]  = out_valid_r;
        assign data_out[a]         = dout_r;
        assign overflow_err[a]     = overflow_r;
    end
endmodule
